// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter/controller.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       grant
);

    logic last_q;

    always_comb begin
        grant = PORT_A;
        if (req == 2'b11) begin
            grant = ~last_q;
        end else if (req[1]) begin
            grant = PORT_B;
        end
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_B;
        end else if (upd) begin
            last_q <= grant;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-port arbitrated controller for an asynchronous SRAM: IDLE -> SETUP -> STROBE(xN) -> HOLD.
module sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_ack,
    output logic              b_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    output logic              ram_oe_n
);

    localparam logic [3:0] LAST_CNT = 4'(STROBE_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              port_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              grant;
    logic              take;
    logic              last_strobe;

    assign take        = (state_q == IDLE) && (a_req || b_req);
    assign last_strobe = (state_q == STROBE) && (cnt_q == LAST_CNT);

    rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   ({b_req, a_req}),
        .upd   (take),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (take) state_d = SETUP;
            SETUP: begin
                state_d = STROBE;
                cnt_d   = '0;
            end
            STROBE: begin
                if (last_strobe) state_d = HOLD;
                else             cnt_d   = cnt_q + 4'd1;
            end
            HOLD: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Request is frozen here; later changes on the port have no effect.
            if (take) begin
                port_q  <= grant;
                we_q    <= (grant == PORT_B) ? b_we    : a_we;
                addr_q  <= (grant == PORT_B) ? b_addr  : a_addr;
                wdata_q <= (grant == PORT_B) ? b_wdata : a_wdata;
            end
            if (last_strobe && !we_q) begin
                if (port_q == PORT_B) b_rdata_q <= ram_data;
                else                  a_rdata_q <= ram_data;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign ram_addr = addr_q;
    assign ram_cs_n = (state_q == IDLE);
    assign ram_we_n = !((state_q == STROBE) && we_q);
    assign ram_oe_n = !((state_q == STROBE) && !we_q);
    assign a_ack    = (state_q == HOLD) && (port_q == PORT_A);
    assign b_ack    = (state_q == HOLD) && (port_q == PORT_B);
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign ram_data = (busy && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule
